packet_source: RTL and testbench

//  Pseudo-random packet injector feeding one router input channel. Generates

---
 rtl/packet_source.sv | 90 +++++++++
 tb/tb_packet_source.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_source.sv
// Pseudo-random packet injector for one router input channel.
// Packets carry an LFSR-derived destination plus an even-parity bit, offered on valid/ready with random idle gaps.
module packet_source #(
  parameter int SEED        = 5,
  parameter int SIZE        = 8,
  parameter int GAP_BITS    = 4,
  parameter int MAX_PACKETS = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic [15:0]     sent_count,
  output logic            done
);

  // Handshake: out_valid/out_data are held stable from the cycle out_valid
  // rises until a rising edge samples out_valid & out_ready; that edge is the
  // transfer. out_ready may change freely and is ignored while out_valid is low.

  localparam int          DEST_BITS = SIZE - 1;
  localparam logic [15:0] SEED_INIT = (SEED[15:0] == 16'd0) ? 16'h0001 : SEED[15:0];

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_adv;
  logic [GAP_BITS-1:0] gap_cnt;
  logic [15:0]         count_inc;
  logic                hit_max;

  assign lfsr_adv  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign count_inc = (sent_count == 16'hFFFF) ? sent_count : sent_count + 16'd1;
  assign hit_max   = (MAX_PACKETS != 0) && (32'(count_inc) == MAX_PACKETS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_GAP;
      gap_cnt    <= '0;
      lfsr       <= SEED_INIT;
      out_valid  <= 1'b0;
      out_data   <= '0;
      sent_count <= 16'd0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_GAP: begin
          if (enable) begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
            end else begin
              // Parity bit on top makes every packet even parity.
              out_data  <= {^lfsr[DEST_BITS-1:0], lfsr[DEST_BITS-1:0]};
              out_valid <= 1'b1;
              lfsr      <= lfsr_adv;
              state     <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            sent_count <= count_inc;
            gap_cnt    <= lfsr[15 -: GAP_BITS];
            lfsr       <= lfsr_adv;
            if (hit_max) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          out_valid <= 1'b0;
        end
        default: state <= ST_GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_source.sv
// Bench for packet_source: directed scenarios plus randomized enable/ready,
// checked against a packet/gap sequence predicted from the LFSR rules.
module tb_packet_source;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_enable = 1'b1;
  logic       a_ready = 1'b1;
  logic       a_valid, m_valid, z_valid;
  logic [7:0] a_data, m_data, z_data;
  logic [15:0] a_sent, m_sent, z_sent;
  logic       a_done, m_done, z_done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] gap_q[$];
  logic [7:0] zq[$];

  always #5 clk = ~clk;

  packet_source #(.SEED(5), .SIZE(8), .GAP_BITS(4), .MAX_PACKETS(0)) dut_a (
    .clk(clk), .reset(reset), .enable(a_enable), .out_valid(a_valid),
    .out_ready(a_ready), .out_data(a_data), .sent_count(a_sent), .done(a_done));

  packet_source #(.SEED(5), .SIZE(8), .GAP_BITS(4), .MAX_PACKETS(3)) dut_m (
    .clk(clk), .reset(reset), .enable(1'b1), .out_valid(m_valid),
    .out_ready(1'b1), .out_data(m_data), .sent_count(m_sent), .done(m_done));

  packet_source #(.SEED(0), .SIZE(8), .GAP_BITS(4), .MAX_PACKETS(0)) dut_z (
    .clk(clk), .reset(reset), .enable(1'b1), .out_valid(z_valid),
    .out_ready(1'b1), .out_data(z_data), .sent_count(z_sent), .done(z_done));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the Galois LFSR as a plain shift/xor on a 16-bit number.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] packet_of(input logic [15:0] l);
    logic [6:0] d;
    d = l[6:0];
    return {^d, d};
  endfunction

  // Gap k is the number of idle cycles before packet k; packet 0 follows reset with gap 0.
  task automatic build_sequence(input logic [15:0] seed, input int n, input bit to_z);
    logic [15:0] l, l1;
    logic [7:0]  g;
    l = seed;
    g = 8'd0;
    for (int k = 0; k < n; k++) begin
      if (to_z) zq.push_back(packet_of(l));
      else begin
        exp_q.push_back(packet_of(l));
        gap_q.push_back(g);
      end
      l1 = lfsr_step(l);
      g  = {4'd0, l1[15:12]};
      l  = lfsr_step(l1);
    end
  endtask

  // Scoreboard for dut_a: gap length counts only enable-high idle cycles.
  int a_idx = 0, a_low = 0, a_cnt = 0;
  bit a_was_valid = 0;
  always @(negedge clk) begin
    if (!reset) begin
      a_idx = 0; a_low = 0; a_cnt = 0; a_was_valid = 0;
    end else begin
      check("a_count", a_sent, a_cnt);
      check("a_done", a_done, 0);
      if (a_valid) begin
        if (a_idx >= exp_q.size()) check("a_overrun", a_idx, exp_q.size());
        else begin
          if (!a_was_valid) begin
            check("a_gap", a_low, gap_q[a_idx] + 1);
            a_low = 0;
          end
          check("a_data", a_data, exp_q[a_idx]);
          check("a_parity", ^a_data, 0);
          if (a_ready) begin a_idx++; a_cnt++; end
        end
      end else if (a_enable) begin
        a_low++;
      end
      a_was_valid = a_valid;
    end
  end

  int m_hs = 0;
  always @(negedge clk) begin
    if (!reset) m_hs = 0;
    else begin
      check("m_done", m_done, (m_hs >= 3) ? 1 : 0);
      if (m_done) check("m_idle", m_valid, 0);
      if (m_valid) begin
        check("m_parity", ^m_data, 0);
        m_hs++;
      end
    end
  end

  int z_idx = 0;
  always @(negedge clk) begin
    if (!reset) z_idx = 0;
    else if (z_valid) begin
      if (z_idx == 0) check("z_first", z_data, 8'h81);
      if (z_idx < zq.size()) check("z_data", z_data, zq[z_idx]);
      check("z_parity", ^z_data, 0);
      z_idx++;
    end
  end

  task automatic wait_valid(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_valid) break;
    end
    check(tag, a_valid, 1);
  endtask

  task automatic check_reset_state();
    check("rst_valid", a_valid, 0);
    check("rst_data", a_data, 0);
    check("rst_count", a_sent, 0);
    check("rst_done", a_done, 0);
    check("rst_m_done", m_done, 0);
  endtask

  initial begin
    build_sequence(16'h0005, 2000, 1'b0);
    build_sequence(16'h0001, 64, 1'b1);

    repeat (3) @(negedge clk);
    check_reset_state();
    @(posedge clk); #1 reset = 1'b1;

    // First packet one edge after release, then a 20-cycle enable freeze in the gap.
    wait_valid(3, "first_valid");
    check("first_pkt", a_data, 8'h05);
    @(posedge clk); #1;
    a_enable = 1'b0;
    a_ready  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("freeze_valid", a_valid, 0);
    end
    @(posedge clk); #1 a_enable = 1'b1;
    wait_valid(30, "second_valid");
    check("second_pkt", a_data, 8'h81);

    // Back-pressure: packet and count must hold while ready is low.
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", a_valid, 1);
      check("hold_data", a_data, 8'h81);
      check("hold_count", a_sent, 1);
    end

    // Reset in the middle of SEND drops the packet and restarts the sequence.
    #2 reset = 1'b0;
    #1;
    check("async_valid", a_valid, 0);
    check("async_count", a_sent, 0);
    repeat (3) begin
      @(negedge clk);
      check_reset_state();
    end
    a_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    wait_valid(3, "restart_valid");
    check("restart_pkt", a_data, 8'h05);

    repeat (3000) begin
      @(posedge clk); #1;
      a_enable = ($urandom_range(0, 3) != 0);
      a_ready  = ($urandom_range(0, 1) == 1);
    end
    a_enable = 1'b1;
    a_ready  = 1'b1;
    repeat (40) @(negedge clk);

    check("m_handshakes", m_hs, 3);
    check("m_done_final", m_done, 1);
    check("m_valid_final", m_valid, 0);
    check("m_count_final", m_sent, 3);
    check("a_progress", (a_idx > 100) ? 1 : 0, 1);
    check("z_progress", (z_idx > 10) ? 1 : 0, 1);
    check("z_done", z_done, 0);
    check("z_count", z_sent, z_idx);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
